// File: rtl/add_arb_pkg.sv
// Shared constants, helpers and pipeline-stage type for the shared-adder arbiter.
// ADD_ARB_CARRY_EN adds a carry bit to every pipeline stage.
package add_arb_pkg;

   localparam int DEF_NREQ = 4;
   localparam int DEF_W    = 64;
   localparam int DEF_LAT  = 1;

   // ID width; never below 1 so a two-requester build still has an ID bit.
   function automatic int clog2(input int n);
      int r;
      r = 1;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   function automatic int wrap_inc(input int base, input int step, input int n);
      return (base + step) % n;
   endfunction

   localparam int DEF_IDW = clog2(DEF_NREQ);

   typedef struct packed {
      logic               valid;
      logic [DEF_IDW-1:0] id;
      logic [DEF_W-1:0]   sum;
`ifdef ADD_ARB_CARRY_EN
      logic               carry;
`endif
   } add_stage_t;

endpackage

// File: rtl/add_pipe.sv
// Registered adder with LAT stages carrying valid and requester ID beside the sum.
// ADD_ARB_CARRY_EN widens the add to W+1 bits and exposes out_carry.
module add_pipe
   import add_arb_pkg::*;
#(
   parameter int W   = DEF_W,
   parameter int LAT = DEF_LAT,
   parameter int IDW = DEF_IDW
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           in_valid,
   input  logic [IDW-1:0] in_id,
   input  logic [W-1:0]   in_a,
   input  logic [W-1:0]   in_b,
   output logic           out_valid,
   output logic [IDW-1:0] out_id,
   output logic [W-1:0]   out_sum
`ifdef ADD_ARB_CARRY_EN
   ,output logic          out_carry
`endif
);

   typedef struct packed {
      logic           valid;
      logic [IDW-1:0] id;
      logic [W-1:0]   sum;
`ifdef ADD_ARB_CARRY_EN
      logic           carry;
`endif
   } stage_t;

   stage_t stage_next;

   always_comb begin
      stage_next       = '0;
      stage_next.valid = in_valid;
      stage_next.id    = in_id;
`ifdef ADD_ARB_CARRY_EN
      {stage_next.carry, stage_next.sum} = {1'b0, in_a} + {1'b0, in_b};
`else
      stage_next.sum = in_a + in_b;
`endif
   end

   // Payload only moves with a valid, so the last stage holds its last result.
   for (genvar gi = 0; gi < LAT; gi++) begin : g_stage
      stage_t stage_reg;
      stage_t stage_in;
      if (gi == 0) begin : g_src
         assign stage_in = stage_next;
      end else begin : g_src
         assign stage_in = g_stage[gi-1].stage_reg;
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset)
            stage_reg <= '0;
         else if (stage_in.valid)
            stage_reg <= stage_in;
         else
            stage_reg.valid <= 1'b0;
      end
   end

   assign out_valid = g_stage[LAT-1].stage_reg.valid;
   assign out_id    = g_stage[LAT-1].stage_reg.id;
   assign out_sum   = g_stage[LAT-1].stage_reg.sum;
`ifdef ADD_ARB_CARRY_EN
   assign out_carry = g_stage[LAT-1].stage_reg.carry;
`endif

endmodule

// File: rtl/add_share_arb.sv
// Round-robin arbiter sharing one pipelined adder among NREQ requesters.
// Define ADD_ARB_CARRY_EN to add the rsp_carry output.
module add_share_arb
   import add_arb_pkg::*;
#(
   parameter int NREQ = DEF_NREQ,
   parameter int W    = DEF_W,
   parameter int LAT  = DEF_LAT
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NREQ-1:0]        req_valid,
   output logic [NREQ-1:0]        req_ready,
   input  logic [NREQ*W-1:0]      req_a,
   input  logic [NREQ*W-1:0]      req_b,
   output logic                   rsp_valid,
   output logic [clog2(NREQ)-1:0] rsp_id,
   output logic [W-1:0]           rsp_q
`ifdef ADD_ARB_CARRY_EN
   ,output logic                  rsp_carry
`endif
);

   localparam int IDW = clog2(NREQ);

   logic [IDW-1:0] ptr_reg;
   logic [IDW-1:0] ptr_next;
   logic [IDW-1:0] gnt_id;
   logic [IDW-1:0] cand;
   logic           gnt_any;
   logic [W-1:0]   sel_a;
   logic [W-1:0]   sel_b;

   // First valid requester at or after ptr, wrapping.
   always_comb begin
      gnt_any = 1'b0;
      gnt_id  = '0;
      cand    = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = IDW'(wrap_inc(int'(ptr_reg), k, NREQ));
         if (!gnt_any && req_valid[cand]) begin
            gnt_any = 1'b1;
            gnt_id  = cand;
         end
      end
   end

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
      assign req_ready[gi] = ~reset & gnt_any & (gnt_id == IDW'(gi));
   end

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (gnt_id == IDW'(k)) begin
            sel_a = req_a[k*W +: W];
            sel_b = req_b[k*W +: W];
         end
      end
   end

   assign ptr_next = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         ptr_reg <= '0;
      else if (gnt_any)
         ptr_reg <= ptr_next;
   end

   add_pipe #(
      .W   (W),
      .LAT (LAT),
      .IDW (IDW)
   ) u_pipe (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (gnt_any),
      .in_id     (gnt_id),
      .in_a      (sel_a),
      .in_b      (sel_b),
      .out_valid (rsp_valid),
      .out_id    (rsp_id),
      .out_sum   (rsp_q)
`ifdef ADD_ARB_CARRY_EN
      ,.out_carry (rsp_carry)
`endif
   );

endmodule

// File: tb/tb_add_share_arb.sv
// Bench for add_share_arb: constant vector table, directed sequences and random traffic
// checked against a cycle-indexed scoreboard of expected responses.
module tb_add_share_arb;

   localparam int NREQ = 4;
   localparam int W    = 64;
   localparam int LAT  = 3;
   localparam int IDW  = 2;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic [NREQ-1:0]   req_valid = '0;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*W-1:0] req_a = '0;
   logic [NREQ*W-1:0] req_b = '0;
   logic              rsp_valid;
   logic [IDW-1:0]    rsp_id;
   logic [W-1:0]      rsp_q;
`ifdef ADD_ARB_CARRY_EN
   logic              rsp_carry;
`endif

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int m_ptr  = 0;

   typedef struct {
      int         due;
      int         id;
      logic [W:0] sum;
   } exp_t;
   exp_t expq[$];

   typedef struct {
      logic [NREQ-1:0] v;
      logic [W-1:0]    a;
      logic [W-1:0]    b;
      logic [NREQ-1:0] rdy;
      logic            vld;
      int              id;
      logic [W-1:0]    q;
      logic            c;
   } vec_t;
   vec_t tbl[6];

   always #5 clk = ~clk;

   add_share_arb #(.NREQ(NREQ), .W(W), .LAT(LAT)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_q     (rsp_q)
`ifdef ADD_ARB_CARRY_EN
      ,.rsp_carry (rsp_carry)
`endif
   );

   task automatic chk(input string nm, input logic [W:0] act, input logic [W:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d: got %0h required %0h", nm, cyc, act, exp);
      end
   endtask

   // Compare this cycle's response against the scoreboard head.
   task automatic check_rsp();
      if (expq.size() > 0 && expq[0].due == cyc) begin
         chk("rsp_valid", (W+1)'(rsp_valid), (W+1)'(1));
         chk("rsp_id", (W+1)'(rsp_id), (W+1)'(expq[0].id));
         chk("rsp_q", (W+1)'(rsp_q), (W+1)'(expq[0].sum[W-1:0]));
`ifdef ADD_ARB_CARRY_EN
         chk("rsp_carry", (W+1)'(rsp_carry), (W+1)'(expq[0].sum[W]));
`endif
         $display("cyc=%0d rsp id=%0d q=%h", cyc, rsp_id, rsp_q);
         void'(expq.pop_front());
      end else begin
         chk("rsp_idle", (W+1)'(rsp_valid), (W+1)'(0));
      end
   endtask

   // One clock cycle of stimulus; the model decides the grant and books the response.
   task automatic step(input logic [NREQ-1:0] v, input logic [NREQ*W-1:0] a,
                       input logic [NREQ*W-1:0] b, output int gid, output logic [NREQ-1:0] rdy);
      logic [NREQ-1:0] exp_rdy;
      int i;
      exp_t e;
      req_valid = v;
      req_a     = a;
      req_b     = b;
      @(negedge clk);
      gid = -1;
      for (int k = 0; k < NREQ; k++) begin
         i = (m_ptr + k) % NREQ;
         if (gid < 0 && v[i]) gid = i;
      end
      exp_rdy = '0;
      if (gid >= 0) exp_rdy[gid] = 1'b1;
      rdy = req_ready;
      chk("req_ready", (W+1)'(rdy), (W+1)'(exp_rdy));
      if (gid >= 0) begin
         e.due = cyc + LAT;
         e.id  = gid;
         e.sum = {1'b0, a[gid*W +: W]} + {1'b0, b[gid*W +: W]};
         expq.push_back(e);
         m_ptr = (gid + 1) % NREQ;
      end
      @(posedge clk);
      #1;
      cyc++;
      check_rsp();
   endtask

   // Asynchronous reset with all requesters asking; outputs must clear before any edge.
   task automatic do_reset();
      req_valid = '1;
      #1 reset = 1'b1;
      #1;
      chk("rst_valid", (W+1)'(rsp_valid), (W+1)'(0));
      chk("rst_id", (W+1)'(rsp_id), (W+1)'(0));
      chk("rst_q", (W+1)'(rsp_q), (W+1)'(0));
      chk("rst_ready", (W+1)'(req_ready), (W+1)'(0));
`ifdef ADD_ARB_CARRY_EN
      chk("rst_carry", (W+1)'(rsp_carry), (W+1)'(0));
`endif
      @(posedge clk);
      #1;
      reset     = 1'b0;
      req_valid = '0;
      expq.delete();
      m_ptr = 0;
      cyc++;
   endtask

   initial begin
      int gid;
      logic [NREQ-1:0] rdy;
      logic [NREQ*W-1:0] av;
      logic [NREQ*W-1:0] bv;
      int fair_exp[3];
      fair_exp = '{3, 1, 3};

      tbl[0] = '{4'b0100, 64'd5, 64'd7, 4'b0100, 1'b1, 2, 64'd12, 1'b0};
      tbl[1] = '{4'b1111, 64'd10, 64'd20, 4'b0001, 1'b1, 0, 64'd30, 1'b0};
      tbl[2] = '{4'b1010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0010, 1'b1, 1, 64'd0, 1'b1};
      tbl[3] = '{4'b1000, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 4'b1000, 1'b1, 3, 64'd0, 1'b1};
      tbl[4] = '{4'b0110, 64'd123, 64'd456, 4'b0010, 1'b1, 1, 64'd579, 1'b0};
      tbl[5] = '{4'b0000, 64'd1, 64'd1, 4'b0000, 1'b0, 0, 64'd0, 1'b0};

      for (int n = 0; n < 6; n++) begin
         do_reset();
         step(tbl[n].v, {NREQ{tbl[n].a}}, {NREQ{tbl[n].b}}, gid, rdy);
         chk("tbl_ready", (W+1)'(rdy), (W+1)'(tbl[n].rdy));
         for (int k = 0; k < LAT - 1; k++) step('0, '0, '0, gid, rdy);
         chk("tbl_rsp_valid", (W+1)'(rsp_valid), (W+1)'(tbl[n].vld));
         if (tbl[n].vld) begin
            chk("tbl_rsp_id", (W+1)'(rsp_id), (W+1)'(tbl[n].id));
            chk("tbl_rsp_q", (W+1)'(rsp_q), (W+1)'(tbl[n].q));
`ifdef ADD_ARB_CARRY_EN
            chk("tbl_rsp_carry", (W+1)'(rsp_carry), (W+1)'(tbl[n].c));
`endif
         end
      end

      // All four held valid from reset: strict rotation, sums 100+i back to back.
      do_reset();
      for (int i = 0; i < NREQ; i++) begin
         av[i*W +: W] = W'(i);
         bv[i*W +: W] = W'(100);
      end
      for (int k = 0; k < 2 * NREQ; k++) begin
         step('1, av, bv, gid, rdy);
         chk("rr_order", (W+1)'(gid), (W+1)'(k % NREQ));
      end
      for (int k = 0; k < LAT; k++) step('0, '0, '0, gid, rdy);

      // Fairness: park the pointer at 2, then requesters 1 and 3 alternate.
      do_reset();
      step(4'b0010, av, bv, gid, rdy);
      for (int k = 0; k < 3; k++) begin
         step(4'b1010, av, bv, gid, rdy);
         chk("fair_order", (W+1)'(gid), (W+1)'(fair_exp[k]));
      end
      for (int k = 0; k < LAT; k++) step('0, '0, '0, gid, rdy);

      // Idle gap: pointer must survive the empty cycle.
      do_reset();
      step(4'b0001, av, bv, gid, rdy);
      step(4'b0000, av, bv, gid, rdy);
      step(4'b0011, av, bv, gid, rdy);
      chk("gap_grant", (W+1)'(gid), (W+1)'(1));
      for (int k = 0; k < LAT; k++) step('0, '0, '0, gid, rdy);

      // Reset with results in flight: nothing may emerge afterwards.
      do_reset();
      for (int k = 0; k < 3; k++) step('1, av, bv, gid, rdy);
      do_reset();
      for (int k = 0; k < LAT + 1; k++) step('0, '0, '0, gid, rdy);
      chk("flush_q", (W+1)'(rsp_q), (W+1)'(0));
      chk("flush_id", (W+1)'(rsp_id), (W+1)'(0));
      av[1*W +: W] = 64'd5;
      bv[1*W +: W] = 64'd6;
      step(4'b0010, av, bv, gid, rdy);
      chk("post_rst_ready", (W+1)'(rdy), (W+1)'(4'b0010));
      for (int k = 0; k < LAT; k++) step('0, '0, '0, gid, rdy);

      // Random traffic against the scoreboard.
      for (int n = 0; n < 300; n++) begin
         for (int i = 0; i < NREQ; i++) begin
            av[i*W +: W] = {$urandom, $urandom};
            bv[i*W +: W] = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) av[i*W +: W] = '1;
         end
         step(NREQ'($urandom_range(0, 15)), av, bv, gid, rdy);
      end
      for (int k = 0; k < LAT; k++) step('0, '0, '0, gid, rdy);
      chk("drain_empty", (W+1)'(expq.size()), (W+1)'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
